// File: rtl/wb_rf_arbiter_if.sv
// Bus bundle between the writeback producers and wb_rf_arbiter.
//   slave  : the arbiter (takes the pipe and multi-cycle requests, drives stall,
//            ready, pending and the register-file write port)
//   master : the producers side (pipeline WB stage, multi-cycle unit, RF/hazard unit)
// Signals:
//   i_wb_valid/i_wb_rd/i_wb_data : pipeline writeback request
//   o_wb_stall                   : pipeline must hold WB this cycle
//   i_mc_valid/i_mc_rd/i_mc_data : multi-cycle result offer, o_mc_ready accepts
//   o_mc_pending/o_mc_pending_rd : holding buffer occupancy for the hazard unit
//   o_rf_we/o_rf_rd/o_rf_wdata   : registered register-file write port
interface wb_rf_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            i_wb_valid;
    logic [4:0]      i_wb_rd;
    logic [XLEN-1:0] i_wb_data;
    logic            o_wb_stall;
    logic            i_mc_valid;
    logic            o_mc_ready;
    logic [4:0]      i_mc_rd;
    logic [XLEN-1:0] i_mc_data;
    logic            o_mc_pending;
    logic [4:0]      o_mc_pending_rd;
    logic            o_rf_we;
    logic [4:0]      o_rf_rd;
    logic [XLEN-1:0] o_rf_wdata;

    modport slave (
        input  i_wb_valid, i_wb_rd, i_wb_data, i_mc_valid, i_mc_rd, i_mc_data,
        output o_wb_stall, o_mc_ready, o_mc_pending, o_mc_pending_rd,
        output o_rf_we, o_rf_rd, o_rf_wdata
    );

    modport master (
        output i_wb_valid, i_wb_rd, i_wb_data, i_mc_valid, i_mc_rd, i_mc_data,
        input  o_wb_stall, o_mc_ready, o_mc_pending, o_mc_pending_rd,
        input  o_rf_we, o_rf_rd, o_rf_wdata
    );
endinterface

// File: rtl/wb_rf_arbiter.sv
// Register-file write-port arbiter. The in-order pipeline writeback has priority;
// multi-cycle results (divider, CSR, late load) wait in a one-entry buffer. After
// STARVE_LIMIT denied cycles the buffer forces a one-cycle pipeline stall so it
// always retires. The register-file write outputs are registered.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : wb_rf_arbiter_if slave modport (pipe request, multi-cycle offer,
//             stall/ready/pending status, registered RF write port)
module wb_rf_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned STARVE_LIMIT = 4   // legal 1..15
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    wb_rf_arbiter_if.slave bus
);
    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StEmpty,
        StFull,
        StForce
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [4:0]      buf_rd_q;
    logic [XLEN-1:0] buf_data_q;
    logic            rf_we_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic       preq;
    logic       mc_take;
    logic       waw_hit;
    logic [3:0] cnt_inc;

    always_comb begin
        // Writes to x0 are dropped and never count as a pipe request.
        preq    = bus.i_wb_valid && (bus.i_wb_rd != 5'd0);
        mc_take = bus.i_mc_valid && (bus.i_mc_rd != 5'd0);
        waw_hit = (bus.i_wb_rd == buf_rd_q);
        cnt_inc = (cnt_q >= Limit) ? cnt_q : cnt_q + 4'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StEmpty;
            cnt_q      <= 4'd0;
            buf_rd_q   <= 5'd0;
            buf_data_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            unique case (state_q)
                StEmpty: begin
                    if (preq) begin
                        rf_we_q    <= 1'b1;
                        rf_rd_q    <= bus.i_wb_rd;
                        rf_wdata_q <= bus.i_wb_data;
                    end
                    // An mc result to x0 is accepted and silently discarded.
                    if (mc_take) begin
                        buf_rd_q   <= bus.i_mc_rd;
                        buf_data_q <= bus.i_mc_data;
                        cnt_q      <= 4'd0;
                        state_q    <= StFull;
                    end
                end
                StFull: begin
                    rf_we_q <= 1'b1;
                    if (!preq) begin
                        rf_rd_q    <= buf_rd_q;
                        rf_wdata_q <= buf_data_q;
                        cnt_q      <= 4'd0;
                        state_q    <= StEmpty;
                    end else begin
                        rf_rd_q    <= bus.i_wb_rd;
                        rf_wdata_q <= bus.i_wb_data;
                        if (waw_hit) begin
                            // Younger pipe result supersedes the buffered one.
                            cnt_q   <= 4'd0;
                            state_q <= StEmpty;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == Limit) begin
                                state_q <= StForce;
                            end
                        end
                    end
                end
                StForce: begin
                    rf_we_q    <= 1'b1;
                    rf_rd_q    <= buf_rd_q;
                    rf_wdata_q <= buf_data_q;
                    cnt_q      <= 4'd0;
                    state_q    <= StEmpty;
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

    assign bus.o_mc_ready      = (state_q == StEmpty);
    assign bus.o_wb_stall      = (state_q == StForce);
    assign bus.o_mc_pending    = (state_q != StEmpty);
    assign bus.o_mc_pending_rd = (state_q != StEmpty) ? buf_rd_q : 5'd0;
    assign bus.o_rf_we         = rf_we_q;
    assign bus.o_rf_rd         = rf_rd_q;
    assign bus.o_rf_wdata      = rf_wdata_q;
endmodule

// File: tb/tb_wb_rf_arbiter.sv
// Self-checking bench for wb_rf_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level model of the holding buffer.
module tb_wb_rf_arbiter;
    localparam int unsigned XLEN  = 32;
    localparam int          LIMIT = 4;

    logic clk;
    logic rst_n;

    wb_rf_arbiter_if #(.XLEN(XLEN)) bus ();

    wb_rf_arbiter #(
        .XLEN        (XLEN),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the buffered result and how many times the pipe has beaten it.
    bit          m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_denied;
    logic        m_we;
    logic [4:0]  m_rf_rd;
    logic [31:0] m_rf_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_valid   = 1'b0;
        m_rd      = 5'd0;
        m_data    = 32'd0;
        m_denied  = 0;
        m_we      = 1'b0;
        m_rf_rd   = 5'd0;
        m_rf_data = 32'd0;
    endtask

    task automatic check_reset_outputs();
        check("rst_we", 32'(bus.o_rf_we), 32'd0);
        check("rst_rd", 32'(bus.o_rf_rd), 32'd0);
        check("rst_wdata", bus.o_rf_wdata, 32'd0);
        check("rst_stall", 32'(bus.o_wb_stall), 32'd0);
        check("rst_pending", 32'(bus.o_mc_pending), 32'd0);
        check("rst_pending_rd", 32'(bus.o_mc_pending_rd), 32'd0);
        check("rst_ready", 32'(bus.o_mc_ready), 32'd1);
    endtask

    // One clock: drive inputs, check status outputs, then check the RF port after the edge.
    task automatic step(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bit forced;
        bit pipe;
        bit was_valid;
        @(negedge clk);
        bus.i_wb_valid = wv;
        bus.i_wb_rd    = wrd;
        bus.i_wb_data  = wd;
        bus.i_mc_valid = mv;
        bus.i_mc_rd    = mrd;
        bus.i_mc_data  = md;
        #1;
        forced = m_valid && (m_denied >= LIMIT);
        check("stall", 32'(bus.o_wb_stall), 32'(forced));
        check("ready", 32'(bus.o_mc_ready), 32'(!m_valid));
        check("pending", 32'(bus.o_mc_pending), 32'(m_valid));
        check("pending_rd", 32'(bus.o_mc_pending_rd), m_valid ? 32'(m_rd) : 32'd0);
        @(posedge clk);
        pipe      = wv && (wrd != 5'd0);
        was_valid = m_valid;
        m_we      = 1'b0;
        if (forced || (m_valid && !pipe)) begin
            m_we      = 1'b1;
            m_rf_rd   = m_rd;
            m_rf_data = m_data;
            m_valid   = 1'b0;
        end else if (pipe) begin
            m_we      = 1'b1;
            m_rf_rd   = wrd;
            m_rf_data = wd;
            if (m_valid) begin
                if (wrd == m_rd) m_valid = 1'b0;
                else m_denied++;
            end
        end
        if (!was_valid && mv && (mrd != 5'd0)) begin
            m_valid  = 1'b1;
            m_rd     = mrd;
            m_data   = md;
            m_denied = 0;
        end
        #1;
        check("rf_we", 32'(bus.o_rf_we), 32'(m_we));
        if (m_we) begin
            check("rf_rd", 32'(bus.o_rf_rd), 32'(m_rf_rd));
            check("rf_wdata", bus.o_rf_wdata, m_rf_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        int bias;
        rst_n          = 1'b0;
        bus.i_wb_valid = 1'b0;
        bus.i_wb_rd    = 5'd0;
        bus.i_wb_data  = 32'd0;
        bus.i_mc_valid = 1'b0;
        bus.i_mc_rd    = 5'd0;
        bus.i_mc_data  = 32'd0;
        model_reset();
        #1;
        check_reset_outputs();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);

        // Pipe-only writes, including a write to x0.
        step(1'b1, 5'd5, 32'hBBBB_BBBB, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        idle(1);

        // Multi-cycle result with an idle pipe; mc result to x0 is discarded.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAAAA_AAAA);
        idle(3);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        idle(2);

        // Starvation: four pipe writes, then a forced stall retires rd=9.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0009);
        for (int i = 0; i < LIMIT + 3; i++) begin
            step(1'b1, 5'd3, 32'h3300_0000 + 32'(i), 1'b0, 5'd0, 32'd0);
        end
        idle(2);

        // WAW kill: younger pipe write to rd=12 supersedes the buffer.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h1212_1212);
        step(1'b1, 5'd12, 32'hCCCC_CCCC, 1'b0, 5'd0, 32'd0);
        idle(4);

        // Reset while FULL: entry lost, outputs reset immediately.
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd14, 32'h1414_1414);
        step(1'b1, 5'd2, 32'h0202_0202, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        bus.i_wb_valid = 1'b0;
        bus.i_mc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Randomized traffic, alternating light and heavy pipe load.
        for (int blk = 0; blk < 16; blk++) begin
            bias = (blk % 2 == 0) ? 40 : 95;
            for (int i = 0; i < 100; i++) begin
                step(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)),
                     $urandom, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            end
        end
        idle(LIMIT + 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
